dev_hex_mux: RTL and testbench

Parametrised, time-multiplexed N-digit seven-segment hex display driver; the multi-digit successor of the single-digit `dev_hex` device. It scans DIGITS common-pin displays in turn, inserts anti-ghosting blank gaps between digits, and latches the displayed value once per frame so digits never tear. It sits between a top-level counter or register file and the board display pins.

---
 rtl/dev_hex_mux.sv | 190 +++++++++++++++++++
 tb/tb_dev_hex_mux.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dev_hex_mux.sv
// dev_hex_mux: time-multiplexed N-digit seven-segment hex display driver.
// Scans DIGITS common-pin displays in turn. A blank gap precedes every lit digit,
// and the displayed value is latched once per frame so digits never tear.
// Optional build macro DEV_HEX_LZB_EN enables leading-zero blanking.
module dev_hex_mux #(
    parameter int DIGITS       = 4,
    parameter int SCAN_CYCLES  = 12000,
    parameter int BLANK_CYCLES = 120,
    parameter int ACTIVE_LOW   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   hex_val,
    input  logic [DIGITS-1:0]     dp,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  frame_done
);

    localparam int   MAXC    = (SCAN_CYCLES > BLANK_CYCLES) ? SCAN_CYCLES : BLANK_CYCLES;
    localparam int   CNT_W   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int   IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic POL     = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [IDX_W-1:0] DIG_LAST   = IDX_W'(DIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t                state_r, state_s;
    logic [IDX_W-1:0]      idx_r, idx_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic [4*DIGITS-1:0]   shadow_hex_r, shadow_hex_s;
    logic [DIGITS-1:0]     shadow_dp_r, shadow_dp_s;
    logic                  capture_s;
    logic                  wrap_s;
    logic                  show_s;
    logic [3:0]            nib_s;
    logic                  dpb_s;
    logic                  blank_s;
    logic [7:0]            seg_raw_s;
    logic [DIGITS-1:0]     dig_raw_s;
    logic [7:0]            seg_r;
    logic [DIGITS-1:0]     dig_sel_r;
    logic                  frame_done_r;
`ifdef DEV_HEX_LZB_EN
    logic                  zero_run_s;
`endif

    // Active-high seven-segment font, bit0..6 = a..g.
    function automatic logic [6:0] font7(input logic [3:0] nib);
        logic [6:0] f;
        case (nib)
            4'h0:    f = 7'h3F;
            4'h1:    f = 7'h06;
            4'h2:    f = 7'h5B;
            4'h3:    f = 7'h4F;
            4'h4:    f = 7'h66;
            4'h5:    f = 7'h6D;
            4'h6:    f = 7'h7D;
            4'h7:    f = 7'h07;
            4'h8:    f = 7'h7F;
            4'h9:    f = 7'h6F;
            4'hA:    f = 7'h77;
            4'hB:    f = 7'h7C;
            4'hC:    f = 7'h39;
            4'hD:    f = 7'h5E;
            4'hE:    f = 7'h79;
            4'hF:    f = 7'h71;
            default: f = 7'h00;
        endcase
        return f;
    endfunction

    // Next-state logic: blank/show phases, digit index and phase counter.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        cnt_s   = cnt_r;
        wrap_s  = 1'b0;
        if (!en) begin
            state_s = ST_BLANK;
            idx_s   = '0;
            cnt_s   = '0;
        end else begin
            case (state_r)
                ST_BLANK: begin
                    if (cnt_r == BLANK_LAST) begin
                        state_s = ST_SHOW;
                        cnt_s   = '0;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                ST_SHOW: begin
                    if (cnt_r == SCAN_LAST) begin
                        state_s = ST_BLANK;
                        cnt_s   = '0;
                        if (idx_r == DIG_LAST) begin
                            idx_s  = '0;
                            wrap_s = 1'b1;
                        end else begin
                            idx_s = idx_r + IDX_W'(1);
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_s = ST_BLANK;
                    idx_s   = '0;
                    cnt_s   = '0;
                end
            endcase
        end
    end

    // Shadow capture once per frame, at the start of digit 0's blank gap.
    always_comb begin
        capture_s = en && (state_r == ST_BLANK) && (idx_r == '0) && (cnt_r == '0);
        if (capture_s) begin
            shadow_hex_s = hex_val;
            shadow_dp_s  = dp;
        end else begin
            shadow_hex_s = shadow_hex_r;
            shadow_dp_s  = shadow_dp_r;
        end
    end

    // Output decode from next state so the registered outputs track the state with no lag.
    always_comb begin
        show_s    = (state_s == ST_SHOW);
        nib_s     = 4'h0;
        dpb_s     = 1'b0;
        blank_s   = 1'b0;
        dig_raw_s = '0;
        for (int i = 0; i < DIGITS; i++) begin
            dig_raw_s[i] = show_s && (idx_s == IDX_W'(i));
            nib_s        = (idx_s == IDX_W'(i)) ? shadow_hex_s[4*i +: 4] : nib_s;
            dpb_s        = (idx_s == IDX_W'(i)) ? shadow_dp_s[i] : dpb_s;
        end
`ifdef DEV_HEX_LZB_EN
        // A digit above 0 is blanked when it and every higher nibble are zero.
        zero_run_s = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_run_s = zero_run_s & (shadow_hex_s[4*i +: 4] == 4'h0);
            blank_s    = (idx_s == IDX_W'(i)) ? zero_run_s : blank_s;
        end
`else
        blank_s = 1'b0;
`endif
        if (show_s) begin
            seg_raw_s = {dpb_s, (blank_s ? 7'h00 : font7(nib_s))};
        end else begin
            seg_raw_s = 8'h00;
        end
    end

    // State, shadow and output registers; polarity applied on the way out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_BLANK;
            idx_r        <= '0;
            cnt_r        <= '0;
            shadow_hex_r <= '0;
            shadow_dp_r  <= '0;
            frame_done_r <= 1'b0;
            seg_r        <= {8{POL}};
            dig_sel_r    <= {DIGITS{POL}};
        end else begin
            state_r      <= state_s;
            idx_r        <= idx_s;
            cnt_r        <= cnt_s;
            shadow_hex_r <= shadow_hex_s;
            shadow_dp_r  <= shadow_dp_s;
            frame_done_r <= wrap_s;
            seg_r        <= seg_raw_s ^ {8{POL}};
            dig_sel_r    <= dig_raw_s ^ {DIGITS{POL}};
        end
    end

    assign seg        = seg_r;
    assign dig_sel    = dig_sel_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_dev_hex_mux.sv
// Testbench for dev_hex_mux (DIGITS=4, SCAN_CYCLES=8, BLANK_CYCLES=2).
// Reference model: cycle index k since frame restart; slot = k%40 / 10, lit when k%10 >= 2.
module tb_dev_hex_mux;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] hex_val;
    logic [3:0]  dp;
    logic [7:0]  seg, seg_al;
    logic [3:0]  dig_sel, dig_sel_al;
    logic        frame_done, frame_done_al;

    int          total;
    int          bad;
    int          k;
    logic [15:0] mhex;
    logic [3:0]  mdp;
    logic [6:0]  font_t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    dev_hex_mux #(.DIGITS(4), .SCAN_CYCLES(8), .BLANK_CYCLES(2), .ACTIVE_LOW(0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .hex_val(hex_val), .dp(dp),
        .seg(seg), .dig_sel(dig_sel), .frame_done(frame_done));

    dev_hex_mux #(.DIGITS(4), .SCAN_CYCLES(8), .BLANK_CYCLES(2), .ACTIVE_LOW(1)) dut_al (
        .clk(clk), .rst_n(rst_n), .en(en), .hex_val(hex_val), .dp(dp),
        .seg(seg_al), .dig_sel(dig_sel_al), .frame_done(frame_done_al));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_seg(int kk);
        int p, d;
        p = kk % 40;
        d = p / 10;
        if ((p % 10) < 2) return 8'h00;
`ifdef DEV_HEX_LZB_EN
        if (d > 0 && (mhex >> (4 * d)) == 16'h0000) return {mdp[d], 7'h00};
`endif
        return {mdp[d], font_t[mhex[4*d +: 4]]};
    endfunction

    function automatic logic [3:0] exp_dig(int kk);
        logic [3:0] one;
        int p;
        one = 4'b0001;
        p = kk % 40;
        if ((p % 10) < 2) return 4'b0000;
        return one << (p / 10);
    endfunction

    function automatic logic exp_fd(int kk);
        return (kk > 0) && ((kk % 40) == 0);
    endfunction

    // Advance one clock; update the model from inputs as seen at the edge.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            k = 0;
        end else if (en) begin
            if ((k % 40) == 0) begin
                mhex = hex_val;
                mdp  = dp;
            end
            k++;
        end else begin
            k = 0;
        end
        #1;
    endtask

    task automatic restart();
        en = 1'b0;
        tick();
        en = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            en = 1'($urandom); hex_val = 16'($urandom); dp = 4'($urandom);
            tick();
            total++;
            if (seg !== 8'h00 || dig_sel !== 4'b0000 || frame_done !== 1'b0) begin
                bad++;
                $display("FAIL reset seg=%h dig=%b fd=%b want 00/0000/0", seg, dig_sel, frame_done);
            end
            total++;
            if (seg_al !== 8'hFF || dig_sel_al !== 4'b1111 || frame_done_al !== 1'b0) begin
                bad++;
                $display("FAIL reset_al seg=%h dig=%b fd=%b want FF/1111/0", seg_al, dig_sel_al, frame_done_al);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        hex_val = 16'h12AF; dp = 4'b0000;
        restart();
        for (int c = 0; c < 85; c++) begin
            tick();
            total++;
            if (seg !== exp_seg(k) || dig_sel !== exp_dig(k) || frame_done !== exp_fd(k)) begin
                bad++;
                $display("FAIL scan k=%0d seg=%h/%h dig=%b/%b fd=%b/%b", k, seg, exp_seg(k),
                         dig_sel, exp_dig(k), frame_done, exp_fd(k));
            end
            if (k == 2) begin
                total++;
                if (seg !== 8'h71 || dig_sel !== 4'b0001) begin
                    bad++;
                    $display("FAIL scan_d0 seg=%h dig=%b want 71/0001", seg, dig_sel);
                end
            end
        end
    endtask

    task automatic test_random();
        restart();
        for (int c = 0; c < 250; c++) begin
            hex_val = 16'($urandom); dp = 4'($urandom);
            tick();
            total++;
            if (seg !== exp_seg(k) || dig_sel !== exp_dig(k) || frame_done !== exp_fd(k) ||
                seg_al !== ~exp_seg(k) || dig_sel_al !== ~exp_dig(k)) begin
                bad++;
                $display("FAIL random k=%0d seg=%h/%h dig=%b/%b fd=%b/%b al=%h/%b", k, seg, exp_seg(k),
                         dig_sel, exp_dig(k), frame_done, exp_fd(k), seg_al, dig_sel_al);
            end
        end
    endtask

    task automatic test_tear();
        hex_val = 16'h12AF; dp = 4'b0000;
        restart();
        for (int c = 0; c < 60; c++) begin
            if (k == 15) hex_val = 16'h0000;
            tick();
            total++;
            if (seg !== exp_seg(k) || dig_sel !== exp_dig(k)) begin
                bad++;
                $display("FAIL tear k=%0d seg=%h/%h dig=%b/%b", k, seg, exp_seg(k), dig_sel, exp_dig(k));
            end
            if (k == 25 || k == 35 || k == 55) begin
                total++;
                if (seg !== ((k == 25) ? 8'h5B : (k == 35) ? 8'h06 : 8'h3F)) begin
                    bad++;
                    $display("FAIL tear_const k=%0d seg=%h", k, seg);
                end
            end
        end
    endtask

    task automatic test_enable();
        int n;
        hex_val = 16'h12AF; dp = 4'b0000;
        restart();
        while (k < 25) tick();
        en = 1'b0;
        tick();
        total++;
        if (seg !== 8'h00 || dig_sel !== 4'b0000 || frame_done !== 1'b0) begin
            bad++;
            $display("FAIL en_off seg=%h dig=%b fd=%b want 00/0000/0", seg, dig_sel, frame_done);
        end
        en = 1'b1;
        n = 0;
        while (n < 100) begin
            tick();
            n++;
            if (n == 2) begin
                total++;
                if (dig_sel !== 4'b0001 || seg !== 8'h71) begin
                    bad++;
                    $display("FAIL en_rise_d0 dig=%b seg=%h want 0001/71", dig_sel, seg);
                end
            end
            if (frame_done === 1'b1) break;
        end
        total++;
        if (n != 40) begin
            bad++;
            $display("FAIL en_first_fd cycles=%0d want 40", n);
        end
    endtask

    task automatic test_active_low();
        hex_val = 16'h0000; dp = 4'b0001;
        restart();
        total++;
        if (seg_al !== 8'hFF || dig_sel_al !== 4'b1111) begin
            bad++;
            $display("FAIL al_dark seg=%h dig=%b want FF/1111", seg_al, dig_sel_al);
        end
        tick(); tick();
        total++;
        if (seg_al !== 8'h40 || dig_sel_al !== 4'b1110) begin
            bad++;
            $display("FAIL al_lit seg=%h dig=%b want 40/1110", seg_al, dig_sel_al);
        end
    endtask

    task automatic test_lzb();
        logic [7:0] hi_want;
`ifdef DEV_HEX_LZB_EN
        hi_want = 8'h00;
`else
        hi_want = 8'h3F;
`endif
        hex_val = 16'h0030; dp = 4'b0000;
        restart();
        for (int c = 0; c < 40; c++) begin
            tick();
            if ((k % 10) == 5) begin
                total++;
                if (seg !== ((k < 20) ? ((k < 10) ? 8'h3F : 8'h4F) : hi_want)) begin
                    bad++;
                    $display("FAIL lzb k=%0d seg=%h hi_want=%h", k, seg, hi_want);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        hex_val = 16'h12AF; dp = 4'b1111;
        restart();
        while (k < 5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (seg !== 8'h00 || dig_sel !== 4'b0000 || seg_al !== 8'hFF || dig_sel_al !== 4'b1111) begin
            bad++;
            $display("FAIL async_rst seg=%h dig=%b al=%h/%b", seg, dig_sel, seg_al, dig_sel_al);
        end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 45; c++) begin
            tick();
            total++;
            if (seg !== exp_seg(k) || dig_sel !== exp_dig(k) || frame_done !== exp_fd(k)) begin
                bad++;
                $display("FAIL post_rst k=%0d seg=%h/%h dig=%b/%b fd=%b/%b", k, seg, exp_seg(k),
                         dig_sel, exp_dig(k), frame_done, exp_fd(k));
            end
        end
    endtask

    initial begin
        total = 0; bad = 0; k = 0; mhex = 16'h0000; mdp = 4'b0000;
        rst_n = 1'b0; en = 1'b0; hex_val = 16'h0000; dp = 4'b0000;
        test_reset();
        test_scan();
        test_random();
        test_tear();
        test_enable();
        test_active_low();
        test_lzb();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
